// File: rtl/line_burst_ctrl_if.sv
//------------------------------------------------------------------------------
// Module   : line_burst_ctrl_if
// Purpose  : Burst-memory bus between the line burst controller and a 64-bit
//            burst memory.  One request channel (address + read/write strobe
//            + write beat, accepted by bmem_ready) and one read-return
//            channel (tagged with the beat's line address).
// Ports    : bmem_addr / bmem_read / bmem_write / bmem_wdata  controller -> mem
//            bmem_ready                                        mem -> controller
//            bmem_raddr / bmem_rdata / bmem_rvalid             mem -> controller
// Modports : master (controller side), slave (memory side)
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface line_burst_ctrl_if;

  // request channel
  logic [31:0] bmem_addr;
  logic        bmem_read;
  logic        bmem_write;
  logic [63:0] bmem_wdata;
  logic        bmem_ready;

  // read-return channel
  logic [31:0] bmem_raddr;
  logic [63:0] bmem_rdata;
  logic        bmem_rvalid;

  modport master (
    output bmem_addr,
    output bmem_read,
    output bmem_write,
    output bmem_wdata,
    input  bmem_ready,
    input  bmem_raddr,
    input  bmem_rdata,
    input  bmem_rvalid
  );

  modport slave (
    input  bmem_addr,
    input  bmem_read,
    input  bmem_write,
    input  bmem_wdata,
    output bmem_ready,
    output bmem_raddr,
    output bmem_rdata,
    output bmem_rvalid
  );

endinterface

`default_nettype wire

// File: rtl/line_burst_ctrl.sv
//------------------------------------------------------------------------------
// Module   : line_burst_ctrl
// Purpose  : Arbitrates I-side line reads and D-side line reads/writebacks
//            onto a single 64-bit burst memory.  A 256-bit line moves as
//            four 64-bit beats.  Reads issue one request and collect four
//            address-tagged return beats; writes stream four beats, each
//            held until the memory accepts it.
// Params   : D_FIRST  0 = round-robin between sides, 1 = D side always wins
// Ports    : clk, rst_n              clock, async active-low reset
//            i_addr/i_read           I-side request (level, held until i_resp)
//            i_rdata/i_resp          I-side returned line / completion pulse
//            d_addr/d_read/d_write   D-side request (level, held until d_resp)
//            d_wdata                 D-side writeback line
//            d_rdata/d_resp          D-side returned line / completion pulse
//            bmem                    burst-memory bus (master modport)
//            busy                    controller is not idle
//            grant_d                 current / last owner (1 = D side)
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module line_burst_ctrl #(
  parameter bit D_FIRST = 1'b0
) (
  input  wire logic           clk,
  input  wire logic           rst_n,

  input  wire logic [31:0]    i_addr,
  input  wire logic           i_read,
  output logic      [255:0]   i_rdata,
  output logic                i_resp,

  input  wire logic [31:0]    d_addr,
  input  wire logic           d_read,
  input  wire logic           d_write,
  input  wire logic [255:0]   d_wdata,
  output logic      [255:0]   d_rdata,
  output logic                d_resp,

  line_burst_ctrl_if.master   bmem,

  output logic                busy,
  output logic                grant_d
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RD_ISSUE   = 3'd1,
    RD_COLLECT = 3'd2,
    WR_BEAT    = 3'd3,
    RESP       = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;        // beat slot index within the line
  logic           owner_q, owner_d;    // 1 = D side owns the transaction
  logic           is_wr_q, is_wr_d;    // transaction is a writeback
  logic [31:0]    addr_q, addr_d;      // line-aligned address
  logic [255:0]   line_q, line_d;      // write data or assembled read line
  logic           prefer_q, prefer_d;  // round-robin pointer, 1 = D preferred

  logic           d_req;
  logic           take_d;
  logic           beat_hit;

  // Low address bits are discarded: every transfer is a whole aligned line,
  // and return beats are matched on the line portion of their address.
  logic           unused_addr_bits;
  assign unused_addr_bits = ^{i_addr[4:0], d_addr[4:0], bmem.bmem_raddr[4:0]};

  assign d_req = d_read | d_write;

  // D wins when I is absent, when D has fixed priority, or when the
  // round-robin pointer currently favours D.
  assign take_d = d_req & (~i_read | D_FIRST | prefer_q);

  assign beat_hit = bmem.bmem_rvalid &&
                    (bmem.bmem_raddr[31:5] == addr_q[31:5]);

  //--------------------------------------------------------------------------
  // Next-state and datapath update
  //--------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    owner_d  = owner_q;
    is_wr_d  = is_wr_q;
    addr_d   = addr_q;
    line_d   = line_q;
    prefer_d = prefer_q;

    unique case (state_q)
      IDLE: begin
        if (i_read || d_req) begin
          owner_d  = take_d;
          prefer_d = ~take_d;
          // read+write together from D counts as a writeback
          is_wr_d  = take_d & d_write;
          addr_d   = {(take_d ? d_addr[31:5] : i_addr[31:5]), 5'b0};
          cnt_d    = 2'd0;
          if (take_d && d_write) begin
            line_d  = d_wdata;
            state_d = WR_BEAT;
          end else begin
            state_d = RD_ISSUE;
          end
        end
      end

      RD_ISSUE: begin
        if (bmem.bmem_ready) begin
          state_d = RD_COLLECT;
        end
      end

      RD_COLLECT: begin
        // beats tagged with some other line belong to someone else
        if (beat_hit) begin
          line_d[{cnt_q, 6'd0} +: 64] = bmem.bmem_rdata;
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = RESP;
          end
        end
      end

      WR_BEAT: begin
        if (bmem.bmem_ready) begin
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d = RESP;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // State and control registers
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 2'd0;
      owner_q  <= 1'b0;
      is_wr_q  <= 1'b0;
      addr_q   <= '0;
      line_q   <= '0;
      prefer_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      owner_q  <= owner_d;
      is_wr_q  <= is_wr_d;
      addr_q   <= addr_d;
      line_q   <= line_d;
      prefer_q <= prefer_d;
    end
  end

  //--------------------------------------------------------------------------
  // Registered outputs.  Each is computed from the next state so that the
  // bus strobes line up with the state they belong to while still coming
  // straight out of flops (no path from bmem inputs to bmem outputs).
  //--------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bmem.bmem_addr  <= '0;
      bmem.bmem_read  <= 1'b0;
      bmem.bmem_write <= 1'b0;
      bmem.bmem_wdata <= '0;
      i_resp          <= 1'b0;
      d_resp          <= 1'b0;
      i_rdata         <= '0;
      d_rdata         <= '0;
    end else begin
      bmem.bmem_read  <= (state_d == RD_ISSUE);
      bmem.bmem_write <= (state_d == WR_BEAT);
      bmem.bmem_addr  <= ((state_d == RD_ISSUE) || (state_d == WR_BEAT)) ?
                         addr_d : '0;
      // the beat on the bus follows cnt, so it only moves once accepted
      bmem.bmem_wdata <= (state_d == WR_BEAT) ?
                         line_d[{cnt_d, 6'd0} +: 64] : '0;

      i_resp <= (state_d == RESP) && !owner_d;
      d_resp <= (state_d == RESP) &&  owner_d;

      // returned lines hold until the same side's next completion;
      // writebacks leave d_rdata untouched
      if ((state_d == RESP) && !owner_d) begin
        i_rdata <= line_d;
      end
      if ((state_d == RESP) && owner_d && !is_wr_d) begin
        d_rdata <= line_d;
      end
    end
  end

  assign busy    = (state_q != IDLE);
  assign grant_d = owner_q;

endmodule

`default_nettype wire

// File: tb/tb_line_burst_ctrl.sv
//------------------------------------------------------------------------------
// Module   : tb_line_burst_ctrl
// Purpose  : Directed self-checking bench for line_burst_ctrl.  A second
//            instance built with D_FIRST=1 shows fixed D priority.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_line_burst_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic [31:0]  i_addr, d_addr;
  logic         i_read, d_read, d_write;
  logic [255:0] d_wdata;
  logic [255:0] i_rdata, d_rdata;
  logic         i_resp, d_resp, busy, grant_d;

  logic         i_read2, d_read2;
  logic [255:0] i_rdata2, d_rdata2;
  logic         i_resp2, d_resp2, busy2, grant_d2;

  line_burst_ctrl_if bus ();
  line_burst_ctrl_if bus2 ();

  int n_cmp = 0;
  int n_err = 0;

  line_burst_ctrl #(.D_FIRST(1'b0)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_addr  (i_addr),
    .i_read  (i_read),
    .i_rdata (i_rdata),
    .i_resp  (i_resp),
    .d_addr  (d_addr),
    .d_read  (d_read),
    .d_write (d_write),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_resp  (d_resp),
    .bmem    (bus),
    .busy    (busy),
    .grant_d (grant_d)
  );

  line_burst_ctrl #(.D_FIRST(1'b1)) dut_dfirst (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_addr  (i_addr),
    .i_read  (i_read2),
    .i_rdata (i_rdata2),
    .i_resp  (i_resp2),
    .d_addr  (d_addr),
    .d_read  (d_read2),
    .d_write (1'b0),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata2),
    .d_resp  (d_resp2),
    .bmem    (bus2),
    .busy    (busy2),
    .grant_d (grant_d2)
  );

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // four matching return beats, data base+0 .. base+3
  task automatic feed(input logic [31:0] a, input logic [63:0] base);
    for (int k = 0; k < 4; k++) begin
      bus.bmem_rvalid = 1'b1;
      bus.bmem_raddr  = a;
      bus.bmem_rdata  = base + 64'(k);
      tick();
    end
    bus.bmem_rvalid = 1'b0;
  endtask

  localparam logic [63:0] BA = 64'hAAAA_0000_0000_0001;
  localparam logic [63:0] BB = 64'hBBBB_0000_0000_0002;
  localparam logic [63:0] BC = 64'hCCCC_0000_0000_0003;
  localparam logic [63:0] BD = 64'hDDDD_0000_0000_0004;
  localparam logic [63:0] L0 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] L1 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] L2 = 64'h3333_3333_3333_3333;
  localparam logic [63:0] L3 = 64'h4444_4444_4444_4444;

  initial begin
    logic exp_d;
    rst_n   = 1'b0;
    i_addr  = '0; i_read = 1'b0;
    d_addr  = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = '0;
    i_read2 = 1'b0; d_read2 = 1'b0;
    bus.bmem_ready  = 1'b0; bus.bmem_rvalid  = 1'b0;
    bus.bmem_raddr  = '0;   bus.bmem_rdata   = '0;
    bus2.bmem_ready = 1'b1; bus2.bmem_rvalid = 1'b0;
    bus2.bmem_raddr = '0;   bus2.bmem_rdata  = '0;

    // ---------------- reset state
    tick(); tick();
    chk("rst_busy",    busy, 0);
    chk("rst_grant",   grant_d, 0);
    chk("rst_bread",   bus.bmem_read, 0);
    chk("rst_baddr",   bus.bmem_addr, 0);
    chk("rst_irdata",  i_rdata, 0);
    rst_n = 1'b1;
    tick();

    // ---------------- I read 0x1234
    i_addr = 32'h0000_1234; i_read = 1'b1; bus.bmem_ready = 1'b1;
    tick();
    chk("ird_bread",   bus.bmem_read, 1);
    chk("ird_baddr",   bus.bmem_addr, 32'h1220);
    chk("ird_bwrite",  bus.bmem_write, 0);
    chk("ird_busy",    busy, 1);
    tick();
    chk("ird_bread_off", bus.bmem_read, 0);
    bus.bmem_rvalid = 1'b1; bus.bmem_raddr = 32'h1220;
    bus.bmem_rdata = BA; tick();
    bus.bmem_rdata = BB; tick();
    bus.bmem_rdata = BC; tick();
    chk("ird_noresp_early", i_resp, 0);
    bus.bmem_rdata = BD; tick();
    bus.bmem_rvalid = 1'b0;
    chk("ird_iresp",   i_resp, 1);
    chk("ird_dresp",   d_resp, 0);
    chk("ird_rdata",   i_rdata, {BD, BC, BB, BA});
    chk("ird_grant",   grant_d, 0);
    i_read = 1'b0;
    tick();
    chk("ird_iresp_pulse", i_resp, 0);
    chk("ird_idle",    busy, 0);
    tick();

    // ---------------- D write 0x80 with ready 1,0,1,1,0,1
    d_addr = 32'h80; d_write = 1'b1; d_wdata = {L3, L2, L1, L0};
    tick();
    d_wdata = '1;  // line must already be latched
    chk("wr_bwrite",   bus.bmem_write, 1);
    chk("wr_bread",    bus.bmem_read, 0);
    chk("wr_baddr",    bus.bmem_addr, 32'h80);
    chk("wr_beat0",    bus.bmem_wdata, L0);
    bus.bmem_ready = 1'b1; tick();
    chk("wr_beat1",    bus.bmem_wdata, L1);
    bus.bmem_ready = 1'b0; tick();
    chk("wr_beat1_hold", bus.bmem_wdata, L1);
    bus.bmem_ready = 1'b1; tick();
    chk("wr_beat2",    bus.bmem_wdata, L2);
    bus.bmem_ready = 1'b1; tick();
    chk("wr_beat3",    bus.bmem_wdata, L3);
    bus.bmem_ready = 1'b0; tick();
    chk("wr_beat3_hold", bus.bmem_wdata, L3);
    chk("wr_noresp",   d_resp, 0);
    bus.bmem_ready = 1'b1; tick();
    chk("wr_dresp",    d_resp, 1);
    chk("wr_iresp",    i_resp, 0);
    chk("wr_bwrite_off", bus.bmem_write, 0);
    chk("wr_drdata_keep", d_rdata, 0);
    chk("wr_grant",    grant_d, 1);
    d_write = 1'b0;
    tick();
    chk("wr_dresp_pulse", d_resp, 0);
    tick();

    // ---------------- D read 0x40 with a stray 0x60 beat
    d_addr = 32'h40; d_read = 1'b1;
    tick();
    chk("str_baddr",   bus.bmem_addr, 32'h40);
    tick();
    bus.bmem_rvalid = 1'b1;
    bus.bmem_raddr = 32'h40; bus.bmem_rdata = 64'h10; tick();
    bus.bmem_raddr = 32'h60; bus.bmem_rdata = 64'hDEAD; tick();
    bus.bmem_raddr = 32'h40; bus.bmem_rdata = 64'h11; tick();
    bus.bmem_rdata = 64'h12; tick();
    chk("str_noresp",  d_resp, 0);
    bus.bmem_rdata = 64'h13; tick();
    bus.bmem_rvalid = 1'b0;
    chk("str_dresp",   d_resp, 1);
    chk("str_rdata",   d_rdata, {64'h13, 64'h12, 64'h11, 64'h10});
    chk("str_irdata_hold", i_rdata, {BD, BC, BB, BA});
    d_read = 1'b0;
    tick(); tick();

    // ---------------- both sides held: round-robin I,D,I,D
    i_addr = 32'h100; d_addr = 32'h200;
    i_read = 1'b1; d_read = 1'b1;
    i_read2 = 1'b1; d_read2 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      exp_d = k[0];
      tick();
      chk("rr_grant",  grant_d, exp_d);
      chk("rr_baddr",  bus.bmem_addr, exp_d ? 32'h200 : 32'h100);
      if (k == 0) begin
        chk("dfirst_grant", grant_d2, 1);
        chk("dfirst_baddr", bus2.bmem_addr, 32'h200);
        i_read2 = 1'b0; d_read2 = 1'b0;
      end
      tick();
      feed(exp_d ? 32'h200 : 32'h100, 64'h5000 + 64'(16 * k));
      chk("rr_iresp",  i_resp, !exp_d);
      chk("rr_dresp",  d_resp, exp_d);
      chk("rr_line",   exp_d ? d_rdata : i_rdata,
          {64'h5003 + 64'(16 * k), 64'h5002 + 64'(16 * k),
           64'h5001 + 64'(16 * k), 64'h5000 + 64'(16 * k)});
      if (k == 3) begin
        i_read = 1'b0; d_read = 1'b0;
      end
      tick();
    end
    tick();

    // ---------------- reset during the second write beat
    d_addr = 32'h80; d_write = 1'b1; d_wdata = {L3, L2, L1, L0};
    bus.bmem_ready = 1'b1;
    tick();
    tick();
    chk("rst_mid_beat1", bus.bmem_wdata, L1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy",   busy, 0);
    chk("arst_bwrite", bus.bmem_write, 0);
    chk("arst_wdata",  bus.bmem_wdata, 0);
    chk("arst_baddr",  bus.bmem_addr, 0);
    chk("arst_irdata", i_rdata, 0);
    chk("arst_drdata", d_rdata, 0);
    chk("arst_grant",  grant_d, 0);
    chk("arst_busy2",  busy2, 0);
    d_write = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    i_addr = 32'h3010; i_read = 1'b1;
    tick();
    chk("post_bread",  bus.bmem_read, 1);
    chk("post_baddr",  bus.bmem_addr, 32'h3000);
    tick();
    feed(32'h3000, 64'h7000);
    chk("post_iresp",  i_resp, 1);
    chk("post_rdata",  i_rdata, {64'h7003, 64'h7002, 64'h7001, 64'h7000});
    i_read = 1'b0;
    tick();
    chk("post_idle",   busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/line_burst_ctrl.md
LINE_BURST_CTRL -- requirements
Module: line_burst_ctrl

Interface
REQ-001 Parameter: D_FIRST, 0, tie-break policy (0 = round-robin, 1 = fixed D-side priority).
REQ-002 clk  in  1  single clock; all state on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 i_addr  in  32  I-side line address.
REQ-005 i_read  in  1  I-side line read request, level, held until i_resp.
REQ-006 i_rdata  out  256  I-side returned line.
REQ-007 i_resp  out  1  I-side completion pulse.
REQ-008 d_addr  in  32  D-side line address.
REQ-009 d_read, d_write  in  1 each  D-side read / writeback request, level, held until d_resp.
REQ-010 d_wdata  in  256  D-side writeback line.
REQ-011 d_rdata  out  256  D-side returned line.
REQ-012 d_resp  out  1  D-side completion pulse.
REQ-013 bmem_addr  out  32; bmem_read, bmem_write  out  1 each; bmem_wdata  out  64: burst memory request.
REQ-014 bmem_ready  in  1  memory accepts request/beat this cycle.
REQ-015 bmem_raddr  in  32; bmem_rdata  in  64; bmem_rvalid  in  1: read-return beat.
REQ-016 busy  out  1  high in any state except IDLE; grant_d  out  1  current/last owner (1 = D).

Function
REQ-017 FSM states SHALL be IDLE, RD_ISSUE, RD_COLLECT, WR_BEAT, RESP.
REQ-018 IDLE: if any request pending, latch owner, address with bits [4:0] zeroed, and (for write) d_wdata; go RD_ISSUE (read) or WR_BEAT (write) next cycle.
REQ-019 Arbitration with both sides pending: D_FIRST=1 -> D wins; D_FIRST=0 -> side not granted last time wins; pointer updates only on grant.
REQ-020 d_read and d_write both high -> treated as write.
REQ-021 RD_ISSUE: bmem_read=1, bmem_addr=latched line address; held until a cycle with bmem_ready=1, then RD_COLLECT; bmem_read low from next cycle.
REQ-022 RD_COLLECT: each bmem_rvalid with bmem_raddr[31:5] equal to latched address[31:5] stores bmem_rdata in beat slot cnt (slot k -> line bits [64k+63:64k]), cnt increments; mismatching beats ignored.
REQ-023 After 4th accepted read beat, cnt wraps to 0, go RESP.
REQ-024 WR_BEAT: bmem_write=1, bmem_addr=latched address, bmem_wdata=latched line slot cnt; cnt advances only on cycles with bmem_ready=1; after 4th accepted beat go RESP.
REQ-025 RESP: exactly one-cycle resp pulse to owner only; rdata output presents assembled line in that cycle and holds it until that side's next resp; writes pulse d_resp with d_rdata unchanged; return to IDLE.
REQ-026 Requester SHALL drop request in resp cycle; request seen in IDLE after RESP is a new transaction.
REQ-027 Request deasserted mid-transaction SHALL NOT abort it; resp still pulses.
REQ-028 bmem_rvalid outside RD_COLLECT ignored; bmem_read and bmem_write never high together.
REQ-029 Minimum latency: write, request in IDLE cycle 0, beats cycles 1-4, resp cycle 5; read, issue cycle 1, resp one cycle after 4th beat.
REQ-030 bmem outputs SHALL be registered; no combinational path from bmem inputs to bmem outputs.

Reset
REQ-031 rst_n low asynchronously SHALL force IDLE, cnt=0, arbitration pointer to I-preferred, all outputs 0 (rdata buses included), regardless of transaction in progress.
REQ-032 After rst_n rises, first request SHALL be accepted no earlier than the next rising edge.

Verification
REQ-033 I read 0x0000_1234, ready=1, beats A,B,C,D with raddr 0x1220 -> bmem_addr 0x1220, i_rdata={D,C,B,A}, single i_resp, d_resp stays 0.
REQ-034 D write 0x80 line L, ready toggling 1,0,1,1,0,1 -> bmem_wdata L[63:0],L[127:64],L[191:128],L[255:192] each held until accepted, d_resp one cycle after last accepted beat.
REQ-035 D_FIRST=0, I and D read asserted continuously -> grants alternate I,D,I,D; D_FIRST=1 -> D granted first.
REQ-036 Read of 0x40 with stray beat raddr 0x60 interleaved -> stray beat ignored, line built from four 0x40 beats only.
REQ-037 rst_n low during 2nd write beat -> outputs 0 immediately, busy=0; new I request after release completes normally.
